// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pkg: shared state encodings, error cause codes and width helper   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package wb_pkg;

  typedef enum logic [1:0] {
    WB_STATE_IDLE   = 2'd0,
    WB_STATE_ACTIVE = 2'd1,
    WB_STATE_DERR   = 2'd2,
    WB_STATE_TERR   = 2'd3
  } wb_state_t;

  localparam logic [1:0] WB_CAUSE_NONE    = 2'd0;
  localparam logic [1:0] WB_CAUSE_DECODE  = 2'd1;
  localparam logic [1:0] WB_CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] WB_CAUSE_SLAVE   = 2'd3;

  // Never returns less than 1 so a single slave still gets a real index bit.
  function automatic int wb_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_addr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_addr_decoder: base/mask address decode, lowest index wins         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_addr_decoder
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_FC00},
  parameter int INDEX_WIDTH = wb_clog2(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0]  i_adr,
  output logic                   o_hit,
  output logic [INDEX_WIDTH-1:0] o_index
);

  logic [NUM_SLAVES-1:0] w_match;

  generate
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_match
      assign w_match[i] = (i_adr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                          == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    o_hit   = |w_match;
    o_index = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) o_index = INDEX_WIDTH'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_interconnect_1xn.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_interconnect_1xn: single-master to N-slave Wishbone B3 routing    |
// | with decode/timeout/slave error reporting. Revision: 1.0             |
// +----------------------------------------------------------------------+
module wb_interconnect_1xn
  import wb_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int NUM_SLAVES     = 2,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_FC00},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic [WB_ADDR_WIDTH-1:0]          wbs_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]          wbs_dat_i,
  input  logic [WB_DATA_WIDTH/8-1:0]        wbs_sel_i,
  input  logic                              wbs_we_i,
  input  logic                              wbs_cyc_i,
  input  logic                              wbs_stb_i,
  output logic [WB_DATA_WIDTH-1:0]          wbs_dat_o,
  output logic                              wbs_ack_o,
  output logic                              wbs_err_o,
  output logic [WB_ADDR_WIDTH-1:0]          wbm_adr_o,
  output logic [WB_DATA_WIDTH-1:0]          wbm_dat_o,
  output logic [WB_DATA_WIDTH/8-1:0]        wbm_sel_o,
  output logic                              wbm_we_o,
  output logic [NUM_SLAVES-1:0]             wbm_cyc_o,
  output logic [NUM_SLAVES-1:0]             wbm_stb_o,
  input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0] wbm_dat_i,
  input  logic [NUM_SLAVES-1:0]             wbm_ack_i,
  input  logic [NUM_SLAVES-1:0]             wbm_err_i,
  output logic [WB_ADDR_WIDTH-1:0]          err_addr_o,
  output logic [1:0]                        err_cause_o
);

  localparam int c_idx_w = wb_clog2(NUM_SLAVES);
  localparam int c_cnt_w = wb_clog2(TIMEOUT_CYCLES + 1);
  localparam bit c_timeout_en = (TIMEOUT_CYCLES != 0);
  localparam logic [c_cnt_w-1:0] c_cnt_last =
    c_timeout_en ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

  wb_state_t                r_state;
  logic [c_idx_w-1:0]       r_sel;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [WB_ADDR_WIDTH-1:0] r_err_addr;
  logic [1:0]               r_err_cause;

  logic                     w_hit;
  logic [c_idx_w-1:0]       w_index;
  logic                     w_slv_ack;
  logic                     w_slv_err;
  logic                     w_timeout;
  logic [WB_DATA_WIDTH-1:0] w_slv_dat [NUM_SLAVES];

  wb_addr_decoder #(
    .NUM_SLAVES  (NUM_SLAVES),
    .ADDR_WIDTH  (WB_ADDR_WIDTH),
    .SLAVE_BASE  (SLAVE_BASE),
    .SLAVE_MASK  (SLAVE_MASK),
    .INDEX_WIDTH (c_idx_w)
  ) u_decoder (
    .i_adr   (wbs_adr_i),
    .o_hit   (w_hit),
    .o_index (w_index)
  );

  generate
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_rdata
      assign w_slv_dat[i] = wbm_dat_i[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    end
  endgenerate

  assign wbm_adr_o   = wbs_adr_i;
  assign wbm_dat_o   = wbs_dat_i;
  assign wbm_sel_o   = wbs_sel_i;
  assign wbm_we_o    = wbs_we_i;
  assign err_addr_o  = r_err_addr;
  assign err_cause_o = r_err_cause;

  // Responses are qualified by cyc so an aborted cycle never leaks an ack/err.
  assign w_slv_ack = wbm_ack_i[r_sel] & wbs_cyc_i;
  assign w_slv_err = wbm_err_i[r_sel] & wbs_cyc_i;
  assign w_timeout = c_timeout_en && (r_cnt == c_cnt_last);

  always_comb begin
    wbm_cyc_o = '0;
    wbm_stb_o = '0;
    wbs_ack_o = 1'b0;
    wbs_err_o = 1'b0;
    wbs_dat_o = '0;
    case (r_state)
      WB_STATE_ACTIVE: begin
        wbm_cyc_o[r_sel] = wbs_cyc_i;
        wbm_stb_o[r_sel] = wbs_stb_i;
        wbs_ack_o        = w_slv_ack & ~w_slv_err;
        wbs_err_o        = w_slv_err;
        wbs_dat_o        = w_slv_dat[r_sel];
      end
      WB_STATE_DERR, WB_STATE_TERR: wbs_err_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state     <= WB_STATE_IDLE;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_err_addr  <= '0;
      r_err_cause <= WB_CAUSE_NONE;
    end else begin
      case (r_state)
        WB_STATE_IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            if (w_hit) begin
              r_sel   <= w_index;
              r_cnt   <= '0;
              r_state <= WB_STATE_ACTIVE;
            end else begin
              r_state     <= WB_STATE_DERR;
              r_err_addr  <= wbs_adr_i;
              r_err_cause <= WB_CAUSE_DECODE;
            end
          end
        end
        WB_STATE_ACTIVE: begin
          if (!wbs_cyc_i) begin
            r_state <= WB_STATE_IDLE;
          end else if (w_slv_err) begin
            r_state     <= WB_STATE_IDLE;
            r_err_addr  <= wbs_adr_i;
            r_err_cause <= WB_CAUSE_SLAVE;
          end else if (w_slv_ack) begin
            r_state <= WB_STATE_IDLE;
          end else begin
            // An ack on the last counted cycle is taken above, so it beats the timeout.
            r_cnt <= r_cnt + 1'b1;
            if (w_timeout) begin
              r_state     <= WB_STATE_TERR;
              r_err_addr  <= wbs_adr_i;
              r_err_cause <= WB_CAUSE_TIMEOUT;
            end
          end
        end
        WB_STATE_DERR, WB_STATE_TERR: r_state <= WB_STATE_IDLE;
        default: r_state <= WB_STATE_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_interconnect_1xn.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_interconnect_1xn: directed bench with transaction-level model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_wb_interconnect_1xn;

  localparam int T = 8;
  localparam int M_NORMAL = 0, M_ERR = 1, M_NEVER = 2;
  localparam int K_ACK = 0, K_DERR = 1, K_TERR = 2, K_SERR = 3, K_ABORT = 4;

  logic        clk, rst_n;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o, wbs_err_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic [1:0]  wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
  logic [63:0] wbm_dat_i;
  logic [31:0] err_addr_o;
  logic [1:0]  err_cause_o;

  wb_interconnect_1xn #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .err_addr_o(err_addr_o), .err_cause_o(err_cause_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave models: fixed latency, optional err, optional spurious ack.
  int          lat [2];
  int          mode [2];
  logic [1:0]  spurious;
  int          s_cnt [2];
  logic [1:0]  s_hit;
  logic [31:0] s_mem [2][16] = '{'{default: 32'h0}, '{1: 32'h1234_5678, default: 32'h0}};

  always_comb begin
    wbm_ack_i = '0;
    wbm_err_i = '0;
    wbm_dat_i = '0;
    s_hit     = '0;
    for (int i = 0; i < 2; i++) begin
      s_hit[i]     = wbm_cyc_o[i] && wbm_stb_o[i] && mode[i] != M_NEVER && s_cnt[i] == lat[i];
      wbm_ack_i[i] = s_hit[i] | spurious[i];
      wbm_err_i[i] = s_hit[i] && mode[i] == M_ERR;
      wbm_dat_i[i*32 +: 32] = s_mem[i][wbm_adr_o[5:2]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!(wbm_cyc_o[i] && wbm_stb_o[i]) || s_hit[i]) s_cnt[i] <= 0;
      else s_cnt[i] <= s_cnt[i] + 1;
      if (s_hit[i] && wbm_we_o && mode[i] != M_ERR) s_mem[i][wbm_adr_o[5:2]] <= wbm_dat_o;
    end
  end

  // Reference model state
  logic [31:0] m_base [2] = '{32'h0000_0000, 32'h1000_0000};
  logic [31:0] m_mask [2] = '{32'hFFFF_FC00, 32'hFFFF_F000};
  logic [31:0] m_mem [2][16] = '{'{default: 32'h0}, '{1: 32'h1234_5678, default: 32'h0}};
  logic [31:0] m_err_addr;
  logic [1:0]  m_err_cause;
  logic [1:0]  exp_cyc;
  logic        exp_ack, exp_err, exp_dat_en, chk_en;
  logic [31:0] exp_dat;
  int          cur_k;
  int          obs_ack_k, obs_err_k;
  logic [31:0] obs_dat;
  logic [1:0]  obs_cyc_or;
  int          n_cmp, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_decode(input logic [31:0] adr, output logic hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < 2; i++) begin
      if (!hit && (adr & m_mask[i]) == m_base[i]) begin
        hit = 1'b1;
        idx = i;
      end
    end
  endfunction

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (cur_k == 0) begin
        obs_ack_k  = -1;
        obs_err_k  = -1;
        obs_cyc_or = '0;
      end
      if (wbs_ack_o) begin obs_ack_k = cur_k; obs_dat = wbs_dat_o; end
      if (wbs_err_o) obs_err_k = cur_k;
      obs_cyc_or |= wbm_cyc_o;
      if (chk_en) begin
        chk("cyc", 64'(wbm_cyc_o), 64'(exp_cyc));
        chk("stb", 64'(wbm_stb_o), 64'(exp_cyc));
        chk("ack", 64'(wbs_ack_o), 64'(exp_ack));
        chk("err", 64'(wbs_err_o), 64'(exp_err));
        if (exp_dat_en) chk("rdata", 64'(wbs_dat_o), 64'(exp_dat));
        chk("err_addr", 64'(err_addr_o), 64'(m_err_addr));
        chk("err_cause", 64'(err_cause_o), 64'(m_err_cause));
        chk("bcast", {wbm_adr_o, wbm_sel_o, wbm_we_o}, {wbs_adr_i, wbs_sel_i, wbs_we_i});
      end
    end
  endtask

  // One master transaction; expected per-cycle outputs derived from decode,
  // slave latency, timeout window and abort point.
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input int abort_at, input int rst_at);
    logic hit, act;
    int   idx, kind, end_k;
    logic [1:0] m_cyc;
    model_decode(adr, hit, idx);
    if (!hit) begin kind = K_DERR; end_k = 1; end
    else if (mode[idx] == M_NEVER || lat[idx] + 1 > T) begin kind = K_TERR; end_k = T + 1; end
    else begin end_k = 1 + lat[idx]; kind = (mode[idx] == M_ERR) ? K_SERR : K_ACK; end
    if (abort_at > 0 && abort_at < end_k) begin kind = K_ABORT; end_k = abort_at; end
    m_cyc = hit ? (2'b01 << idx) : 2'b00;
    for (int k = 0; k <= end_k + 1; k++) begin
      @(posedge clk); #1;
      cur_k = k;
      act = (kind == K_ABORT) ? (k < end_k) : (k <= end_k);
      wbs_cyc_i = act; wbs_stb_i = act; wbs_adr_i = adr;
      wbs_we_i = we; wbs_dat_i = wdat; wbs_sel_i = 4'hF;
      exp_cyc = (k >= 1 && k <= end_k && !((kind == K_TERR || kind == K_ABORT) && k == end_k)) ? m_cyc : 2'b00;
      exp_ack = (kind == K_ACK && k == end_k);
      exp_err = (kind == K_DERR || kind == K_TERR || kind == K_SERR) && k == end_k;
      exp_dat = (exp_ack && !we) ? m_mem[idx][adr[5:2]] : 32'h0;
      exp_dat_en = (k == 0) || (k == end_k + 1) || (exp_err && kind != K_SERR) || (exp_ack && !we);
      if ((kind == K_DERR || kind == K_TERR) && k == end_k) begin
        m_err_addr = adr; m_err_cause = (kind == K_DERR) ? 2'd1 : 2'd2;
      end
      if (kind == K_SERR && k == end_k + 1) begin m_err_addr = adr; m_err_cause = 2'd3; end
      if (kind == K_ACK && we && k == end_k + 1) m_mem[idx][adr[5:2]] = wdat;
      if (rst_at > 0 && k == rst_at) begin
        chk("pre_rst_cyc", 64'(wbm_cyc_o), 64'(2'b10));
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cyc", 64'(wbm_cyc_o), 64'h0);
        chk("rst_stb", 64'(wbm_stb_o), 64'h0);
        chk("rst_ackerr", 64'({wbs_ack_o, wbs_err_o}), 64'h0);
        chk("rst_dat", 64'(wbs_dat_o), 64'h0);
        chk("rst_err_addr", 64'(err_addr_o), 64'h0);
        chk("rst_err_cause", 64'(err_cause_o), 64'h0);
        m_err_addr = '0; m_err_cause = '0;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; rst_n = 1'b1;
        exp_cyc = '0; exp_ack = 1'b0; exp_err = 1'b0; exp_dat_en = 1'b1; exp_dat = '0;
        chk_en = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cur_k = -1; chk_en = 1'b0;
    rst_n = 1'b0; wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    lat = '{1, 3}; mode = '{M_NORMAL, M_NORMAL}; spurious = '0;
    m_err_addr = '0; m_err_cause = '0;
    exp_cyc = '0; exp_ack = 1'b0; exp_err = 1'b0; exp_dat_en = 1'b1; exp_dat = '0;
    fork compare_loop(); join_none
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cyc", 64'(wbm_cyc_o), 64'h0);
    chk("reset_ackerr", 64'({wbs_ack_o, wbs_err_o}), 64'h0);
    chk("reset_err_regs", {err_addr_o, 30'h0, err_cause_o}, 64'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_txn(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0, 0);
    run_txn(32'h0000_0010, 1'b0, 32'h0, 0, 0);
    chk("rd0_ack_k", 64'(obs_ack_k), 64'd2);
    chk("rd0_data", 64'(obs_dat), 64'hDEAD_BEEF);
    chk("rd0_cyc", 64'(obs_cyc_or), 64'(2'b01));

    spurious[0] = 1'b1;
    run_txn(32'h1000_0004, 1'b0, 32'h0, 0, 0);
    spurious[0] = 1'b0;
    chk("rd1_ack_k", 64'(obs_ack_k), 64'd4);
    chk("rd1_data", 64'(obs_dat), 64'h1234_5678);
    chk("rd1_cyc", 64'(obs_cyc_or), 64'(2'b10));

    run_txn(32'h2000_0000, 1'b0, 32'h0, 0, 0);
    chk("derr_k", 64'(obs_err_k), 64'd1);
    chk("derr_addr", 64'(err_addr_o), 64'h2000_0000);
    chk("derr_cause", 64'(err_cause_o), 64'd1);
    chk("derr_cyc", 64'(obs_cyc_or), 64'h0);

    lat[1] = 7;
    run_txn(32'h1000_0008, 1'b0, 32'h0, 0, 0);
    chk("edge_ack_k", 64'(obs_ack_k), 64'd8);
    chk("edge_no_err", 64'(obs_err_k), 64'hFFFF_FFFF_FFFF_FFFF);

    lat[1] = 8;
    run_txn(32'h1000_000C, 1'b0, 32'h0, 0, 0);
    chk("terr_k", 64'(obs_err_k), 64'd9);
    chk("terr_cause", 64'(err_cause_o), 64'd2);
    chk("terr_addr", 64'(err_addr_o), 64'h1000_000C);

    lat[1] = 3; mode[1] = M_NEVER;
    run_txn(32'h1000_0010, 1'b0, 32'h0, 0, 0);
    chk("never_k", 64'(obs_err_k), 64'd9);
    run_txn(32'h0000_0010, 1'b0, 32'h0, 0, 0);
    chk("after_to_data", 64'(obs_dat), 64'hDEAD_BEEF);

    mode[1] = M_NORMAL; lat[1] = 5;
    run_txn(32'h1000_0004, 1'b0, 32'h0, 3, 0);
    chk("abort_no_resp", 64'({obs_ack_k, obs_err_k}), {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    chk("abort_cause_kept", 64'(err_cause_o), 64'd2);

    mode[0] = M_ERR;
    run_txn(32'h0000_0020, 1'b0, 32'h0, 0, 0);
    mode[0] = M_NORMAL;
    chk("serr_k", 64'(obs_err_k), 64'd2);
    chk("serr_no_ack", 64'(obs_ack_k), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("serr_cause", 64'(err_cause_o), 64'd3);

    mode[1] = M_NEVER;
    run_txn(32'h1000_0008, 1'b0, 32'h0, 0, 3);
    mode[1] = M_NORMAL; lat[1] = 3;
    run_txn(32'h1000_0004, 1'b0, 32'h0, 0, 0);
    chk("post_rst_ack_k", 64'(obs_ack_k), 64'd4);
    chk("post_rst_data", 64'(obs_dat), 64'h1234_5678);

    run_txn(32'h1000_0014, 1'b1, 32'hCAFE_F00D, 0, 0);
    run_txn(32'h1000_0014, 1'b0, 32'h0, 0, 0);
    chk("wr1_data", 64'(obs_dat), 64'hCAFE_F00D);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
